// File: rtl/wb_lsu_master.sv
// Wishbone B4 classic-cycle load/store initiator: one single-word bus cycle per CPU request.
// Optional ack watchdog enabled by defining LSU_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module wb_lsu_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [29:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i
);

    // One-hot states so every handshake output is a flop bit, never a decode.
    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_BUS  = 3'b010;
    localparam logic [2:0] ST_RESP = 3'b100;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
        $error("wb_lsu_master: TIMEOUT_CYCLES must be nonzero");
    end

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_sel(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] sel;
        case (size)
            SZ_BYTE: sel = 4'b0001 << off;
            SZ_HALF: sel = 4'b0011 << off;
            SZ_WORD: sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{wdata[7:0]}};
            SZ_HALF: rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] load_ext(input logic [1:0] size, input logic [1:0] off,
                                             input logic sgn, input logic [31:0] data);
        logic [31:0] shifted;
        logic [31:0] ext;
        shifted = data >> {off, 3'b000};
        case (size)
            SZ_BYTE: ext = {{24{sgn & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ext = {{16{sgn & shifted[15]}}, shifted[15:0]};
            default: ext = data;
        endcase
        return ext;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [29:0] adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [31:0] dat_q, dat_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        sgn_q, sgn_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        bad_s;
    logic        timeout_s;

    assign bad_s = misaligned(req_size, req_addr[1:0]);

`ifdef LSU_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    assign timeout_s = (tmo_cnt_q == 32'(TIMEOUT_CYCLES));

    // Watchdog counts un-acked BUS cycles and is zero whenever BUS is entered.
    always_comb begin
        tmo_cnt_d = 32'd0;
        if ((state_q == ST_BUS) && !ack_i) begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end else begin
            tmo_cnt_d = 32'd0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tmo_cnt_q <= 32'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack arriving together with the watchdog limit wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = bad_s ? ST_RESP : ST_BUS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (ack_i || timeout_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_BUS;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are straight state flop bits.
    always_comb begin
        req_ready  = state_q[0];
        cyc_o      = state_q[1];
        stb_o      = state_q[1];
        resp_valid = state_q[2];
    end

    // Request capture, bus setup and response formation.
    always_comb begin
        adr_d   = adr_q;
        sel_d   = sel_q;
        we_d    = we_q;
        dat_d   = dat_q;
        size_d  = size_q;
        off_d   = off_q;
        sgn_d   = sgn_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d  = req_size;
                    off_d   = req_addr[1:0];
                    sgn_d   = req_signed;
                    rdata_d = 32'd0;
                    if (bad_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        adr_d = req_addr[31:2];
                        sel_d = byte_sel(req_size, req_addr[1:0]);
                        we_d  = req_we;
                        dat_d = lane_rep(req_size, req_wdata);
                    end
                end else begin
                    err_d = 1'b0;
                end
            end
            ST_BUS: begin
                if (ack_i) begin
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : load_ext(size_q, off_q, sgn_q, dat_i);
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            ST_RESP: begin
                err_d   = 1'b0;
                rdata_d = 32'd0;
            end
            default: begin
                err_d   = 1'b0;
                rdata_d = 32'd0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            adr_q   <= 30'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            dat_q   <= 32'd0;
            size_q  <= 2'd0;
            off_q   <= 2'd0;
            sgn_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            dat_q   <= dat_d;
            size_q  <= size_d;
            off_q   <= off_d;
            sgn_q   <= sgn_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign adr_o      = adr_q;
    assign sel_o      = sel_q;
    assign we_o       = we_q;
    assign dat_o      = dat_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: doc/wb_lsu_master.md
Name: wb_lsu_master

Overview:
- Wishbone B4 classic-cycle initiator that turns CPU load/store requests into single 32-bit Wishbone cycles toward the word-addressed data memory.
- Generates the byte selects and steers the write data onto the correct lanes.
- Extracts the read data and sign- or zero-extends it, then returns one response per request.
- Sits between the core's memory stage and the memory/interconnect slave port.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles in BUS with no ack before the watchdog aborts; only used with LSU_TIMEOUT_EN.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_signed  in  1  sign-extend load result
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size, or timeout
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  Wishbone write enable
- adr_o  out  30  word address = req_addr[31:2]
- sel_o  out  4  byte lane select
- dat_o  out  32  write data
- dat_i  in  32  read data
- ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset values: cyc_o, stb_o, we_o, resp_valid, resp_err = 0; adr_o, sel_o, dat_o, resp_rdata = 0; state = IDLE.
- Reset is synchronous. Asserting sys_rst mid-cycle drops cyc_o/stb_o at the next edge and discards the request with no response.
- States:
  - IDLE: req_ready = 1.
  - BUS: cyc_o = stb_o = 1.
  - RESP: resp_valid = 1 and cyc_o = stb_o = 0.
- IDLE, on accept (req_valid && req_ready):
  - Latch the request.
  - Alignment errors: req_size 11, half with addr[0] = 1, or word with addr[1:0] != 0. Go to RESP with resp_err = 1 and issue no bus cycle.
  - Otherwise register adr_o, sel_o, we_o and dat_o, and go to BUS.
- All Wishbone outputs are registered. cyc_o/stb_o rise on the edge after acceptance.
- BUS: hold every output stable until ack_i is sampled high, then go to RESP. On a load, latch the extended read data into resp_rdata on the same edge.
- RESP lasts exactly one cycle, then IDLE. There is no response backpressure.
- Bus-idle gap: cyc_o/stb_o stay low for at least the RESP and IDLE cycles between transactions. The memory slave needs one idle cycle to clear its serviced flag; without it a stale ack would result.
- Latency against the zero-wait memory slave:
  - Accept at cycle N; stb_o high N+1; ack_i high N+2; resp_valid N+3.
  - Next accept at N+4 at the earliest.
- sel_o generation:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Store lane replication:
  - byte: dat_o = {4{wdata[7:0]}}
  - half: dat_o = {2{wdata[15:0]}}
  - word: dat_o = wdata
- Load extraction:
  - shifted = dat_i >> (8*addr[1:0]).
  - byte takes shifted[7:0]; half takes shifted[15:0].
  - Extend with bit 7 or bit 15 if req_signed, else zero-extend. Word is passed through and req_signed is ignored.
- Stores: resp_rdata = 0 and resp_err = 0.
- ack_i is ignored outside BUS.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- With the macro:
  - An 8..32-bit counter clears on entering BUS and increments each BUS cycle without ack.
  - When it equals TIMEOUT_CYCLES, drop cyc_o/stb_o on the next edge and go to RESP with resp_err = 1 and resp_rdata = 0.
  - If ack_i is high in the same cycle the limit is reached, the ack wins and no error is reported.
- Without the macro: BUS waits for ack_i indefinitely, no counter logic exists, and TIMEOUT_CYCLES is unused.

Test Plan:
- Memory word 0 = 0xDEAD8FF1; load byte, signed, addr 0x0 -> sel_o 0001, adr_o 0, resp_rdata 0xFFFFFFF1, resp_err 0, resp_valid at accept+3.
- Load half, unsigned, addr 0x2 -> sel_o 1100, resp_rdata 0x0000DEAD. Load word, addr 0x0 -> resp_rdata 0xDEAD8FF1.
- Store byte 0x5A to addr 0x105 -> adr_o 0x41, sel_o 0010, dat_o 0x5A5A5A5A, we_o 1. A following word load of 0x104 returns byte1 = 0x5A with the other bytes unchanged.
- Word load at addr 0x2, then half load at 0x1, then size 11 -> each gives resp_err 1 with cyc_o never asserted, one cycle after accept.
- Back-to-back requests with req_valid held high -> stb_o low for at least 2 cycles between cycles, each ack consumed once, two correct responses.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES = 4 and ack_i tied 0 -> stb_o drops after the count reaches 4, resp_err 1. With sys_rst pulsed during BUS -> cyc_o 0 next edge, no resp_valid, req_ready 1.
